// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator with a registered, handshaked output.
// A main + skid register pair absorbs execute back-pressure without dropping or repeating entries.
module imm_gen_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       IMMSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_illegal
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holding valid keeps its payload unchanged until that transfer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      imm32;
    logic [XLEN-1:0]  imm_ext;
    logic             ill_ext;

    logic [XLEN-1:0]  main_imm, skid_imm;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             main_ill, skid_ill;

    logic in_fire, out_fire;
    logic load_main, main_from_skid, load_skid;

    // Every format is first built as a 32-bit value, then sign-extended to XLEN;
    // the zero-extended formats have bit 31 clear so the extension leaves them zero-extended.
    always_comb begin
        imm32   = '0;
        ill_ext = 1'b0;
        case (IMMSrc)
            3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm32 = {instr[31:12], 12'b0};
            3'b100: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101: imm32 = 32'(instr[20 +: SHAMT_W]);
            3'b110: imm32 = {27'b0, instr[19:15]};
            default: begin
                imm32   = '0;
                ill_ext = 1'b1;
            end
        endcase
        imm_ext = XLEN'($signed(imm32));
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Flush only moves the state; payload registers keep their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_imm <= '0;
            main_tag <= '0;
            main_ill <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_ill <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                if (main_from_skid) begin
                    main_imm <= skid_imm;
                    main_tag <= skid_tag;
                    main_ill <= skid_ill;
                end else begin
                    main_imm <= imm_ext;
                    main_tag <= in_tag;
                    main_ill <= ill_ext;
                end
            end
            if (load_skid) begin
                skid_imm <= imm_ext;
                skid_tag <= in_tag;
                skid_ill <= ill_ext;
            end
        end
    end

    assign ImmOp       = main_imm;
    assign out_tag     = main_tag;
    assign imm_illegal = main_ill;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=32 and an XLEN=64 instance share all inputs and
// are checked against a queue-based model of the stage contents.
module tb_imm_gen_stage;

    localparam int W = 129; // {ill, tag[31:0], imm32[31:0], imm64[63:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [2:0]  IMMSrc = '0;
    logic [31:0] in_tag = '0;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    int n_checks = 0;
    int n_fail = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   emitted[$];
    logic          last_in_fire = 1'b0;

    imm_gen_stage #(.XLEN(32), .SHAMT_W(5), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .IMMSrc(IMMSrc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .ImmOp(imm32), .out_tag(tag32), .imm_illegal(ill32)
    );

    imm_gen_stage #(.XLEN(64), .SHAMT_W(6), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .IMMSrc(IMMSrc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .ImmOp(imm64), .out_tag(tag64), .imm_illegal(ill64)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit x64);
        longint v;
        case (src)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31:12], 12'h000}));
            3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd5: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: v = 0;
        endcase
        return v;
    endfunction

    // ---------------- scoreboard (samples on falling edge) ----------------
    always @(negedge clk) begin
        logic [W-1:0] front;
        logic [63:0]  r32, r64;
        if (!rst_n) begin
            exp_q.delete();
            last_in_fire = 1'b0;
        end else begin
            n_checks++;
            if (out_valid32 !== (exp_q.size() > 0) || out_valid64 !== (exp_q.size() > 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %0b/%0b want %0b", out_valid32, out_valid64,
                         exp_q.size() > 0);
            end
            n_checks++;
            if (in_ready32 !== (exp_q.size() < 2) || in_ready64 !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL in_ready: got %0b/%0b want %0b", in_ready32, in_ready64,
                         exp_q.size() < 2);
            end
            if (exp_q.size() > 0) begin
                front = exp_q[0];
                n_checks++;
                if (imm32 !== front[95:64] || imm64 !== front[63:0]) begin
                    n_fail++;
                    $display("FAIL ImmOp: got %h/%h want %h/%h", imm32, imm64,
                             front[95:64], front[63:0]);
                end
                n_checks++;
                if (tag32 !== front[127:96] || tag64 !== front[127:96]) begin
                    n_fail++;
                    $display("FAIL out_tag: got %h/%h want %h", tag32, tag64, front[127:96]);
                end
                n_checks++;
                if (ill32 !== front[128] || ill64 !== front[128]) begin
                    n_fail++;
                    $display("FAIL imm_illegal: got %0b/%0b want %0b", ill32, ill64, front[128]);
                end
            end
            if (out_valid32 && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                emitted.push_back(tag32);
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready32) begin
                r32 = ref_imm(instr, IMMSrc, 1'b0);
                r64 = ref_imm(instr, IMMSrc, 1'b1);
                exp_q.push_back({(IMMSrc == 3'b111), in_tag, r32[31:0], r64});
            end
            last_in_fire = in_valid & in_ready32 & ~flush;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== '0 || tag32 !== '0 ||
            ill32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset32: got v=%0b r=%0b imm=%h tag=%h ill=%0b want 0 1 0 0 0",
                     out_valid32, in_ready32, imm32, tag32, ill32);
        end
        n_checks++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || imm64 !== '0 || tag64 !== '0 ||
            ill64 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset64: got v=%0b r=%0b imm=%h tag=%h ill=%0b want 0 1 0 0 0",
                     out_valid64, in_ready64, imm64, tag64, ill64);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_formats32();
        logic [31:0] f_instr[3] = '{32'hFFF00093, 32'hFE000EE3, 32'hFE000EE3};
        logic [2:0]  f_src[3]   = '{3'b000, 3'b010, 3'b111};
        logic [31:0] f_imm[3]   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000};
        logic        f_ill[3]   = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            instr    = f_instr[i];
            IMMSrc   = f_src[i];
            in_tag   = 32'h100 + 32'(i);
            step();
            n_checks++;
            if (out_valid32 !== 1'b1 || imm32 !== f_imm[i] || ill32 !== f_ill[i]) begin
                n_fail++;
                $display("FAIL fmt32_%0d: got v=%0b imm=%h ill=%0b want 1 %h %0b", i,
                         out_valid32, imm32, ill32, f_imm[i], f_ill[i]);
            end
        end
        drain();
    endtask

    task automatic test_formats64();
        logic [31:0] f_instr[3] = '{32'h800002B7, 32'h03F01013, 32'h000FD073};
        logic [2:0]  f_src[3]   = '{3'b011, 3'b101, 3'b110};
        logic [63:0] f_imm[3]   = '{64'hFFFFFFFF80000000, 64'd63, 64'd31};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            instr    = f_instr[i];
            IMMSrc   = f_src[i];
            in_tag   = 32'h200 + 32'(i);
            step();
            n_checks++;
            if (out_valid64 !== 1'b1 || imm64 !== f_imm[i] || ill64 !== 1'b0) begin
                n_fail++;
                $display("FAIL fmt64_%0d: got v=%0b imm=%h ill=%0b want 1 %h 0", i,
                         out_valid64, imm64, ill64, f_imm[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[3] = '{32'hA, 32'hB, 32'hC};
        bit got_c = 1'b0;
        emitted.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = $urandom;
        IMMSrc    = 3'b000;
        in_tag    = 32'hA;
        step();
        instr  = $urandom;
        in_tag = 32'hB;
        step();
        n_checks++;
        if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_in_ready: got %0b/%0b want 0", in_ready32, in_ready64);
        end
        instr  = $urandom;
        in_tag = 32'hC;
        repeat (2) step();
        n_checks++;
        if (tag32 !== 32'hA || in_ready32 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_A: got tag=%h rdy=%0b want a 0", tag32, in_ready32);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10 && !got_c; c++) begin
            step();
            got_c = last_in_fire;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!got_c) begin
            n_fail++;
            $display("FAIL accept_C: got none want accept within 10 cycles");
        end
        for (int c = 0; c < 10 && emitted.size() < 3; c++) step();
        repeat (2) step();
        n_checks++;
        if (emitted.size() != 3) begin
            n_fail++;
            $display("FAIL order_count: got %0d want 3", emitted.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (emitted[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL order_%0d: got %h want %h", i, emitted[i], want[i]);
                end
            end
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        IMMSrc    = 3'b001;
        instr     = $urandom;
        in_tag    = 32'hD;
        step();
        instr  = $urandom;
        in_tag = 32'hE;
        step();
        instr  = $urandom;
        in_tag = 32'hF;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_two: got v=%0b r=%0b want 0 1", out_valid32, in_ready32);
        end
        in_valid = 1'b1;
        instr    = $urandom;
        in_tag   = 32'h10;
        step();
        in_tag = 32'h11;
        flush  = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_one: got v=%0b r=%0b want 0 1", out_valid32, in_ready32);
        end
        emitted.delete();
        out_ready = 1'b1;
        repeat (4) step();
        n_checks++;
        if (emitted.size() != 0) begin
            n_fail++;
            $display("FAIL flush_emit: got %0d entries want 0", emitted.size());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        IMMSrc    = 3'b011;
        instr     = 32'h80000000 | $urandom;
        in_tag    = 32'h20;
        step();
        in_tag = 32'h21;
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== '0 || tag32 !== '0 ||
            imm64 !== '0 || out_valid64 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b r=%0b imm=%h tag=%h want 0 1 0 0",
                     out_valid32, in_ready32, imm32, tag32);
        end
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        emitted.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        IMMSrc    = 3'b000;
        instr     = 32'h00500093;
        in_tag    = 32'h22;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid32 !== 1'b1 || tag32 !== 32'h22 || imm32 !== 32'd5) begin
            n_fail++;
            $display("FAIL post_reset: got v=%0b tag=%h imm=%h want 1 22 5",
                     out_valid32, tag32, imm32);
        end
        repeat (2) step();
        n_checks++;
        if (emitted.size() != 1) begin
            n_fail++;
            $display("FAIL post_reset_emit: got %0d entries want 1", emitted.size());
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_in_fire) begin
                in_valid = ($urandom_range(0, 9) < 7);
                instr    = $urandom;
                IMMSrc   = 3'($urandom_range(0, 7));
                in_tag   = $urandom;
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_formats32();
        test_formats64();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
